heap_array_allocator: RTL and testbench
=======================================

HEAP_ARRAY_ALLOCATOR -- requirements
Module: heap_array_allocator

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of every data/index/address bus.
REQ-002 SHALL have parameter NArea, default 10, heap elements per array.
REQ-003 SHALL have parameter NArrays, default 20, maximum array count and freed-stack depth.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low): clock in 1 system clock; reset_n in 1 async active-low reset; req[1:0] in 2 per-requester request; op[1:0] in 2 per-requester op (0=alloc, 1=free); idx_in[1:0] in 2xMEW array to free; ack[1:0] out 2 one-cycle completion; err out 1 valid with ack, request failed; array_out out MEW allocated index, valid with ack on alloc; heap_we out 1; heap_addr out MEW; heap_wdata out MEW; size_we out 1; size_idx out MEW; in_use out MEW live arrays; busy out 1 FSM not IDLE.

Function
REQ-005 SHALL run FSM IDLE -> EXEC -> (CLEAR ->) ACK -> IDLE, one state per cycle.
REQ-006 IDLE: if any req high, SHALL grant by round-robin (pointer favours requester not served last; pointer resets to 0), latch op/idx_in, enter EXEC; else stay.
REQ-007 EXEC alloc: freed-stack non-empty -> pop top (LIFO); else allocs<NArrays -> use allocs, allocs+=1; else err=1, enter ACK.
REQ-008 EXEC alloc success SHALL pulse size_we=1 with size_idx=array for that cycle and enter CLEAR with counter 0.
REQ-009 CLEAR SHALL, for NArea consecutive cycles, drive heap_we=1, heap_addr=array*NArea+counter, heap_wdata=0, then enter ACK.
REQ-010 EXEC free: idx>=allocs, or stack holding NArrays entries -> err=1; else push idx; enter ACK in both cases.
REQ-011 ACK SHALL assert ack only for granted requester, drive err and array_out (array_out=0 on free or error), flip pointer.
REQ-012 Alloc latency SHALL be NArea+2 cycles from the IDLE grant edge to ack; free latency 2 cycles.
REQ-013 Requester SHALL hold req/op/idx_in stable until ack and drop req on the edge ack is sampled; allocator never re-grants in the IDLE cycle after ACK from a dropped req.
REQ-014 Simultaneous req[0] and req[1] SHALL be served in turn, no request lost; loser waits in IDLE.
REQ-015 in_use SHALL equal allocs minus freed-stack depth, updated on the EXEC edge.
REQ-016 heap_we, size_we, ack SHALL be 0 outside their stated states; address/data buses SHALL be 0 when not enabled.
REQ-017 Double free of a live index is not detected; behaviour is defined as a normal push.

Reset
REQ-018 reset_n low SHALL asynchronously force IDLE, allocs=0, stack empty, pointer=0, all outputs 0.
REQ-019 Reset mid-CLEAR SHALL abandon the clear and issue no ack; the array counts as unallocated afterwards.

Structure
REQ-020 Package zero_heap_pkg SHALL hold MemoryElementWidth/NArea/NArrays defaults, op encoding, FSM state enum.
REQ-021 Freed-array LIFO SHALL be sub-module freed_array_stack (push, pop, top, depth, empty, full).
REQ-022 Heap and arraySizes memories SHALL stay outside this block; only write ports are driven.

Verification
REQ-023 After reset, req[0] alloc -> ack[0] 12 cycles later, array_out=0, heap_we high 10 cycles addresses 0..9, in_use=1.
REQ-024 Same-cycle alloc on req[0] and req[1] -> req[0] acked with 0, then req[1] acked with 1, in_use=2.
REQ-025 Alloc 0,1,2; free 1; alloc -> array_out=1 (LIFO reuse), heap addresses 10..19 cleared, in_use=3.
REQ-026 20 allocs then 21st -> err=1, array_out=0, no heap_we; free idx 25 -> err=1, in_use unchanged at 20.
REQ-027 reset_n low during 5th CLEAR cycle -> outputs 0 immediately, no ack, next alloc returns 0.

Source files
------------

// File: rtl/zero_heap_pkg.sv
// Shared definitions for the zero-initialising heap array allocator:
// default sizes, request op encoding and the allocator FSM states.
package zero_heap_pkg;

   localparam int DefMemoryElementWidth = 12;
   localparam int DefNArea              = 10;
   localparam int DefNArrays            = 20;

   typedef enum logic {
      OpAlloc = 1'b0,
      OpFree  = 1'b1
   } opKind_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StExec  = 2'd1,
      StClear = 2'd2,
      StAck   = 2'd3
   } allocState_t;

endpackage

// File: rtl/freed_array_stack.sv
// LIFO of freed array indices. The most recently freed index is reused
// first. Push and pop are never requested in the same cycle by the owner.
module freed_array_stack #(
   parameter int Width  = 12,
   parameter int Depth  = 20,
   parameter int DepthW = $clog2(Depth + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [Width-1:0]  pushData,
   output logic [Width-1:0]  top,
   output logic [DepthW-1:0] depth,
   output logic              empty,
   output logic              full
);

   localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0]  entries [Depth];
   logic [DepthW-1:0] count;

   // Occupancy counter; reset empties the stack.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

   // Entry storage; slots at or above count are don't-care, so no reset.
   always_ff @(posedge clock) begin
      if (push && !full) begin
         entries[IdxW'(count)] <= pushData;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == DepthW'(Depth));
   assign depth = count;
   assign top   = empty ? '0 : entries[IdxW'(count - 1'b1)];

endmodule

// File: rtl/heap_array_allocator.sv
// Two-requester array allocator. An alloc hands out a fixed-size array
// (NArea heap words), records it in the size memory and zero-fills its
// heap region before acknowledging. Freed indices go to a LIFO for reuse.
// Handshake: a requester raises req with op/idx_in stable and keeps them
// stable until it samples its ack bit high (a one-cycle pulse); it drops
// req on that same edge. err and array_out are valid only with ack.
module heap_array_allocator
   import zero_heap_pkg::*;
#(
   parameter int MemoryElementWidth = DefMemoryElementWidth,
   parameter int NArea              = DefNArea,
   parameter int NArrays            = DefNArrays
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [1:0]                        req,
   input  logic [1:0]                        op,
   input  logic [2*MemoryElementWidth-1:0]   idx_in,
   output logic [1:0]                        ack,
   output logic                              err,
   output logic [MemoryElementWidth-1:0]     array_out,
   output logic                              heap_we,
   output logic [MemoryElementWidth-1:0]     heap_addr,
   output logic [MemoryElementWidth-1:0]     heap_wdata,
   output logic                              size_we,
   output logic [MemoryElementWidth-1:0]     size_idx,
   output logic [MemoryElementWidth-1:0]     in_use,
   output logic                              busy
);

   localparam int Mew    = MemoryElementWidth;
   localparam int DepthW = $clog2(NArrays + 1);

   allocState_t     state;
   opKind_t         curOp;
   logic            grantId;
   logic            rrPtr;
   logic            allocOk;
   logic [Mew-1:0]  curIdx;
   logic [Mew-1:0]  curArray;
   logic [Mew-1:0]  allocs;
   logic [Mew-1:0]  clearCnt;

   logic [1:0]      ackReg;
   logic            errReg;
   logic [Mew-1:0]  arrayOutReg;
   logic            heapWeReg;
   logic [Mew-1:0]  heapAddrReg;
   logic            sizeWeReg;
   logic [Mew-1:0]  sizeIdxReg;

   logic              stackPush;
   logic              stackPop;
   logic              stackEmpty;
   logic              stackFull;
   logic [Mew-1:0]    stackTop;
   logic [DepthW-1:0] stackDepth;

   logic            grantSel;
   logic            candOk;
   logic [Mew-1:0]  candArray;
   logic            freeErr;

   // Grant choice and the array an alloc would receive if granted now;
   // the stack and allocs cannot change between grant and EXEC.
   always_comb begin
      grantSel  = req[rrPtr] ? rrPtr : ~rrPtr;
      candOk    = !stackEmpty || (allocs < Mew'(NArrays));
      candArray = !stackEmpty ? stackTop : allocs;
      freeErr   = (curIdx >= allocs) || stackFull;
      stackPop  = (state == StExec) && (curOp == OpAlloc) && allocOk && !stackEmpty;
      stackPush = (state == StExec) && (curOp == OpFree) && !freeErr;
   end

   freed_array_stack #(
      .Width (Mew),
      .Depth (NArrays),
      .DepthW(DepthW)
   ) uFreedStack (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (stackPush),
      .pop     (stackPop),
      .pushData(curIdx),
      .top     (stackTop),
      .depth   (stackDepth),
      .empty   (stackEmpty),
      .full    (stackFull)
   );

   // Allocator FSM with registered outputs; async reset abandons any clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= StIdle;
         curOp       <= OpAlloc;
         grantId     <= 1'b0;
         rrPtr       <= 1'b0;
         allocOk     <= 1'b0;
         curIdx      <= '0;
         curArray    <= '0;
         allocs      <= '0;
         clearCnt    <= '0;
         ackReg      <= '0;
         errReg      <= 1'b0;
         arrayOutReg <= '0;
         heapWeReg   <= 1'b0;
         heapAddrReg <= '0;
         sizeWeReg   <= 1'b0;
         sizeIdxReg  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (|req) begin
                  grantId  <= grantSel;
                  curOp    <= opKind_t'(op[grantSel]);
                  curIdx   <= grantSel ? idx_in[2*Mew-1:Mew] : idx_in[Mew-1:0];
                  allocOk  <= candOk;
                  curArray <= candArray;
                  // size_we is high for exactly the EXEC cycle of a good alloc
                  if ((opKind_t'(op[grantSel]) == OpAlloc) && candOk) begin
                     sizeWeReg  <= 1'b1;
                     sizeIdxReg <= candArray;
                  end
                  state <= StExec;
               end
            end
            StExec: begin
               sizeWeReg  <= 1'b0;
               sizeIdxReg <= '0;
               if (curOp == OpAlloc) begin
                  if (allocOk) begin
                     if (stackEmpty) begin
                        allocs <= allocs + 1'b1;
                     end
                     heapWeReg   <= 1'b1;
                     heapAddrReg <= curArray * Mew'(NArea);
                     clearCnt    <= '0;
                     state       <= StClear;
                  end else begin
                     ackReg      <= grantId ? 2'b10 : 2'b01;
                     errReg      <= 1'b1;
                     arrayOutReg <= '0;
                     state       <= StAck;
                  end
               end else begin
                  ackReg      <= grantId ? 2'b10 : 2'b01;
                  errReg      <= freeErr;
                  arrayOutReg <= '0;
                  state       <= StAck;
               end
            end
            StClear: begin
               if (clearCnt == Mew'(NArea - 1)) begin
                  heapWeReg   <= 1'b0;
                  heapAddrReg <= '0;
                  clearCnt    <= '0;
                  ackReg      <= grantId ? 2'b10 : 2'b01;
                  errReg      <= 1'b0;
                  arrayOutReg <= curArray;
                  state       <= StAck;
               end else begin
                  clearCnt    <= clearCnt + 1'b1;
                  heapAddrReg <= heapAddrReg + 1'b1;
               end
            end
            StAck: begin
               ackReg      <= '0;
               errReg      <= 1'b0;
               arrayOutReg <= '0;
               rrPtr       <= ~grantId;
               state       <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign ack        = ackReg;
   assign err        = errReg;
   assign array_out  = arrayOutReg;
   assign heap_we    = heapWeReg;
   assign heap_addr  = heapAddrReg;
   assign heap_wdata = '0;
   assign size_we    = sizeWeReg;
   assign size_idx   = sizeIdxReg;
   assign in_use     = allocs - Mew'(stackDepth);
   assign busy       = (state != StIdle);

endmodule

// File: tb/tb_heap_array_allocator.sv
// Bench for heap_array_allocator: scenario tasks run in sequence, a
// background monitor pops expected acks from exp_q and logs heap/size writes.
module tb_heap_array_allocator;

   localparam int W  = 12;
   localparam int NA = 10;
   localparam int NR = 20;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic [1:0]     req = '0;
   logic [1:0]     op = '0;
   logic [2*W-1:0] idx_in = '0;
   logic [1:0]     ack;
   logic           err;
   logic [W-1:0]   array_out;
   logic           heap_we;
   logic [W-1:0]   heap_addr;
   logic [W-1:0]   heap_wdata;
   logic           size_we;
   logic [W-1:0]   size_idx;
   logic [W-1:0]   in_use;
   logic           busy;

   int total = 0;
   int bad = 0;

   // expected ack record: {requester, err, array_out}
   logic [W+1:0] exp_q[$];
   logic [W-1:0] heapLog[$];
   logic [W-1:0] sizeLog[$];

   heap_array_allocator #(
      .MemoryElementWidth(W),
      .NArea             (NA),
      .NArrays           (NR)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .op        (op),
      .idx_in    (idx_in),
      .ack       (ack),
      .err       (err),
      .array_out (array_out),
      .heap_we   (heap_we),
      .heap_addr (heap_addr),
      .heap_wdata(heap_wdata),
      .size_we   (size_we),
      .size_idx  (size_idx),
      .in_use    (in_use),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic monitor();
      logic [W+1:0] e;
      forever begin
         @(negedge clock);
         if (heap_we === 1'b1) begin
            heapLog.push_back(heap_addr);
            total++;
            if (heap_wdata !== '0) begin
               bad++;
               $display("FAIL heap_wdata: got %0h, required 0", heap_wdata);
            end
         end
         if (size_we === 1'b1) sizeLog.push_back(size_idx);
         if (ack !== 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ack: ack=%b with nothing expected", ack);
            end else begin
               e = exp_q.pop_front();
               if (ack === 2'b11 || {ack[1], err, array_out} !== e) begin
                  bad++;
                  $display("FAIL ack_result: got ack=%b err=%b out=%0d, required req%0d err=%b out=%0d",
                           ack, err, array_out, e[W+1], e[W], e[W-1:0]);
               end
            end
         end else begin
            total++;
            if (err !== 1'b0 || array_out !== '0 ||
                (heap_we !== 1'b1 && heap_addr !== '0) ||
                (size_we !== 1'b1 && size_idx !== '0)) begin
               bad++;
               $display("FAIL idle_buses: err=%b out=%0d heap_addr=%0d size_idx=%0d, required all 0",
                        err, array_out, heap_addr, size_idx);
            end
         end
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req = '0;
      op = '0;
      idx_in = '0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      exp_q.delete();
      heapLog.delete();
      sizeLog.delete();
   endtask

   // Starts at posedge+1; returns at posedge+1 after req is dropped.
   task automatic do_request(input int r, input logic isFree, input logic [W-1:0] idx,
                             input logic expErr, input logic [W-1:0] expOut,
                             input int expLat, input bit doPush);
      int n;
      bit seen;
      logic rb;
      rb = r[0];
      n = 0;
      seen = 0;
      if (doPush) exp_q.push_back({rb, expErr, expOut});
      op[r] = isFree;
      idx_in[r*W +: W] = idx;
      req[r] = 1'b1;
      while (!seen && n < 200) begin
         @(negedge clock);
         n++;
         if (ack[r] === 1'b1) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL ack_timeout req%0d: no ack in %0d cycles, required an ack", r, n);
      end else if (expLat >= 0) begin
         total++;
         if (n - 1 != expLat) begin
            bad++;
            $display("FAIL latency req%0d: got %0d cycles, required %0d", r, n - 1, expLat);
         end
      end
      @(posedge clock);
      #1 req[r] = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      total++;
      if ({ack, err, array_out, heap_we, heap_addr, size_we, size_idx, in_use, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: ack=%b err=%b out=%0d we=%b addr=%0d swe=%b sidx=%0d in_use=%0d busy=%b, required all 0",
                  ack, err, array_out, heap_we, heap_addr, size_we, size_idx, in_use, busy);
      end
      apply_reset();
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || in_use !== '0) begin
         bad++;
         $display("FAIL reset_idle: busy=%b in_use=%0d, required 0 0", busy, in_use);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_alloc();
      apply_reset();
      do_request(0, 1'b0, '0, 1'b0, W'(0), NA + 2, 1);
      total++;
      if (in_use !== W'(1)) begin
         bad++;
         $display("FAIL single_in_use: got %0d, required 1", in_use);
      end
      total++;
      if (heapLog.size() != NA) begin
         bad++;
         $display("FAIL single_heap_count: got %0d writes, required %0d", heapLog.size(), NA);
      end else begin
         for (int i = 0; i < NA; i++) begin
            total++;
            if (heapLog[i] !== W'(i)) begin
               bad++;
               $display("FAIL single_heap_addr[%0d]: got %0d, required %0d", i, heapLog[i], i);
            end
         end
      end
      total++;
      if (sizeLog.size() != 1 || sizeLog[0] !== W'(0)) begin
         bad++;
         $display("FAIL single_size_write: got %0d writes, required one write of index 0", sizeLog.size());
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      exp_q.push_back({1'b0, 1'b0, W'(0)});
      exp_q.push_back({1'b1, 1'b0, W'(1)});
      fork
         do_request(0, 1'b0, '0, 1'b0, W'(0), NA + 2, 0);
         do_request(1, 1'b0, '0, 1'b0, W'(1), 2 * (NA + 2) + 1, 0);
      join
      total++;
      if (in_use !== W'(2)) begin
         bad++;
         $display("FAIL simul_in_use: got %0d, required 2", in_use);
      end
   endtask

   task automatic test_lifo_reuse();
      apply_reset();
      do_request(0, 1'b0, '0, 1'b0, W'(0), NA + 2, 1);
      do_request(1, 1'b0, '0, 1'b0, W'(1), NA + 2, 1);
      do_request(0, 1'b0, '0, 1'b0, W'(2), NA + 2, 1);
      do_request(1, 1'b1, W'(1), 1'b0, W'(0), 2, 1);
      total++;
      if (in_use !== W'(2)) begin
         bad++;
         $display("FAIL lifo_in_use_after_free: got %0d, required 2", in_use);
      end
      heapLog.delete();
      do_request(0, 1'b0, '0, 1'b0, W'(1), NA + 2, 1);
      total++;
      if (heapLog.size() != NA) begin
         bad++;
         $display("FAIL lifo_heap_count: got %0d writes, required %0d", heapLog.size(), NA);
      end else begin
         for (int i = 0; i < NA; i++) begin
            total++;
            if (heapLog[i] !== W'(NA + i)) begin
               bad++;
               $display("FAIL lifo_heap_addr[%0d]: got %0d, required %0d", i, heapLog[i], NA + i);
            end
         end
      end
      total++;
      if (in_use !== W'(3)) begin
         bad++;
         $display("FAIL lifo_in_use: got %0d, required 3", in_use);
      end
   endtask

   task automatic test_exhaust();
      int r;
      apply_reset();
      for (int i = 0; i < NR; i++) begin
         r = $urandom_range(0, 1);
         do_request(r, 1'b0, '0, 1'b0, W'(i), NA + 2, 1);
      end
      total++;
      if (in_use !== W'(NR)) begin
         bad++;
         $display("FAIL exhaust_in_use_full: got %0d, required %0d", in_use, NR);
      end
      heapLog.delete();
      sizeLog.delete();
      r = $urandom_range(0, 1);
      do_request(r, 1'b0, '0, 1'b1, W'(0), 2, 1);
      total++;
      if (heapLog.size() != 0 || sizeLog.size() != 0) begin
         bad++;
         $display("FAIL exhaust_no_writes: got %0d heap and %0d size writes, required 0 0",
                  heapLog.size(), sizeLog.size());
      end
      do_request(1 - r, 1'b1, W'(25), 1'b1, W'(0), 2, 1);
      total++;
      if (in_use !== W'(NR)) begin
         bad++;
         $display("FAIL exhaust_bad_free_in_use: got %0d, required %0d", in_use, NR);
      end
      do_request(0, 1'b1, W'(7), 1'b0, W'(0), 2, 1);
      total++;
      if (in_use !== W'(NR - 1)) begin
         bad++;
         $display("FAIL exhaust_free_in_use: got %0d, required %0d", in_use, NR - 1);
      end
      heapLog.delete();
      do_request(1, 1'b0, '0, 1'b0, W'(7), NA + 2, 1);
      total++;
      if (heapLog.size() != NA || heapLog[0] !== W'(7 * NA) || heapLog[NA-1] !== W'(7 * NA + NA - 1)) begin
         bad++;
         $display("FAIL exhaust_reuse_heap: got %0d writes, required %0d from %0d", heapLog.size(), NA, 7 * NA);
      end
   endtask

   task automatic test_reset_mid_clear();
      int weCnt;
      int n;
      apply_reset();
      op[0] = 1'b0;
      req[0] = 1'b1;
      weCnt = 0;
      n = 0;
      while (weCnt < 5 && n < 100) begin
         @(negedge clock);
         n++;
         if (heap_we === 1'b1) weCnt++;
      end
      total++;
      if (weCnt != 5) begin
         bad++;
         $display("FAIL midclear_reach: got %0d clear cycles, required 5", weCnt);
      end
      #1 reset_n = 1'b0;
      #1;
      total++;
      if ({ack, err, array_out, heap_we, heap_addr, size_we, size_idx, in_use, busy} !== '0) begin
         bad++;
         $display("FAIL midclear_outputs: we=%b addr=%0d in_use=%0d busy=%b ack=%b, required all 0",
                  heap_we, heap_addr, in_use, busy, ack);
      end
      req[0] = 1'b0;
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         total++;
         if (ack !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midclear_no_ack: ack=%b busy=%b, required 00 0", ack, busy);
         end
      end
      @(posedge clock);
      #1;
      do_request(0, 1'b0, '0, 1'b0, W'(0), NA + 2, 1);
      total++;
      if (in_use !== W'(1)) begin
         bad++;
         $display("FAIL midclear_in_use: got %0d, required 1", in_use);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_alloc();
      test_simultaneous();
      test_lifo_reuse();
      test_exhaust();
      test_reset_mid_clear();
      repeat (3) @(posedge clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected: %0d acks never seen, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
